// File: rtl/lcd_pkg.sv
// Shared types, command constants and timing defaults for the LCD write scheduler.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_EXEC      = 3'd5
  } state_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // 50 MHz clock: 80 ns setup, 500 ns strobe, 80 ns hold, 40 us / 1.64 ms execution
  localparam int unsigned DEF_SETUP_CYC     = 4;
  localparam int unsigned DEF_EN_CYC        = 25;
  localparam int unsigned DEF_HOLD_CYC      = 4;
  localparam int unsigned DEF_EXEC_CYC      = 2000;
  localparam int unsigned DEF_LONG_EXEC_CYC = 82000;
  localparam int unsigned DEF_CNT_W         = 17;

  // Clear Display and Return Home (0x02 and its don't-care alias 0x03) need the long wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == (CMD_CLEAR | CMD_HOME)));
  endfunction

endpackage

// File: rtl/lcd_write_scheduler_if.sv
// Requester ports, init handshake and LCD pins of the write scheduler.
interface lcd_write_scheduler_if;

  logic       i_init_done;
  logic       i_req0;
  logic       i_rs0;
  logic [7:0] i_data0;
  logic       o_ack0;
  logic       i_req1;
  logic       i_rs1;
  logic [7:0] i_data1;
  logic       o_ack1;
  logic       o_lcd_en;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_dados;
  logic       o_busy;

  modport master (
    output i_init_done, i_req0, i_rs0, i_data0, i_req1, i_rs1, i_data1,
    input  o_ack0, o_ack1, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_dados, o_busy
  );

  modport slave (
    input  i_init_done, i_req0, i_rs0, i_data0, i_req1, i_rs1, i_data1,
    output o_ack0, o_ack1, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_dados, o_busy
  );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-way combinational round-robin arbiter; on contention the requester not served last wins.
module lcd_rr_arbiter (
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  output logic [1:0] o_grant
);

  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_rr_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Shares the character LCD bus between two requesters after init, generating the EN strobe timing.
module lcd_write_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC        = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
  parameter int unsigned EXEC_CYC      = DEF_EXEC_CYC,
  parameter int unsigned LONG_EXEC_CYC = DEF_LONG_EXEC_CYC,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst_n,
  lcd_write_scheduler_if.slave bus
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;
  logic             w_cnt_done;
  logic [1:0]       w_grant;
  logic             r_rr_last;
  logic             r_long;
  logic             r_en;
  logic             r_rs;
  logic [7:0]       r_data;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_busy;

  lcd_rr_arbiter u_arbiter (
    .i_req     ({bus.i_req1, bus.i_req0}),
    .i_rr_last (r_rr_last),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_limit = '0;
    case (r_state)
      ST_SETUP: w_limit = CNT_W'(SETUP_CYC - 1);
      ST_PULSE: w_limit = CNT_W'(EN_CYC - 1);
      ST_HOLD:  w_limit = CNT_W'(HOLD_CYC - 1);
      ST_EXEC:  w_limit = r_long ? CNT_W'(LONG_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
      default:  w_limit = '0;
    endcase
  end

  assign w_cnt_done = (r_cnt == w_limit);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_WAIT_INIT;
      r_cnt     <= '0;
      r_rr_last <= 1'b1;
      r_long    <= 1'b0;
      r_en      <= 1'b0;
      r_rs      <= 1'b0;
      r_data    <= 8'h00;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_WAIT_INIT: begin
          if (bus.i_init_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (!bus.i_init_done) begin
            r_state <= ST_WAIT_INIT;
            r_busy  <= 1'b1;
          end else if (|w_grant) begin
            r_rs      <= w_grant[1] ? bus.i_rs1 : bus.i_rs0;
            r_data    <= w_grant[1] ? bus.i_data1 : bus.i_data0;
            r_long    <= w_grant[1] ? is_long_cmd(bus.i_rs1, bus.i_data1)
                                    : is_long_cmd(bus.i_rs0, bus.i_data0);
            r_ack0    <= w_grant[0];
            r_ack1    <= w_grant[1];
            r_rr_last <= w_grant[1];
            r_cnt     <= '0;
            r_state   <= ST_SETUP;
            r_busy    <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_en    <= 1'b1;
            r_state <= ST_PULSE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_state <= ST_EXEC;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          // a mid-transfer loss of init_done is only acted on once the LCD has executed the byte
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_state <= bus.i_init_done ? ST_IDLE : ST_WAIT_INIT;
            r_busy  <= !bus.i_init_done;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_WAIT_INIT;
          r_cnt   <= '0;
          r_en    <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ack0      = r_ack0;
  assign bus.o_ack1      = r_ack1;
  assign bus.o_lcd_en    = r_en;
  assign bus.o_lcd_rs    = r_rs;
  assign bus.o_lcd_rw    = 1'b0;
  assign bus.o_lcd_dados = r_data;
  assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Randomised bench for lcd_write_scheduler against a transaction-level timing and arbitration model.
module tb_lcd_write_scheduler;

  localparam int unsigned SETUP = 4;
  localparam int unsigned EN    = 25;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned EXEC  = 200;
  localparam int unsigned LONG  = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_win = 1;

  lcd_write_scheduler_if bus ();

  lcd_write_scheduler #(
    .SETUP_CYC     (SETUP),
    .EN_CYC        (EN),
    .HOLD_CYC      (HOLD),
    .EXEC_CYC      (EXEC),
    .LONG_EXEC_CYC (LONG),
    .CNT_W         (17)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: write length and arbitration winner from the block's rules.
  function automatic int model_exec(input logic rs, input logic [7:0] d);
    if (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) return LONG;
    return EXEC;
  endfunction

  function automatic int model_total(input logic rs, input logic [7:0] d);
    return SETUP + EN + HOLD + model_exec(rs, d);
  endfunction

  function automatic int model_winner(input logic r0, input logic r1);
    if (r0 && r1) return (last_win == 0) ? 1 : 0;
    if (r1) return 1;
    return 0;
  endfunction

  task automatic wait_ack(input int budget, output int which, output int t);
    which = -1;
    t = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_ack0 === 1'b1 || bus.o_ack1 === 1'b1) begin
        which = (bus.o_ack1 === 1'b1) ? ((bus.o_ack0 === 1'b1) ? 2 : 1) : 0;
        t = cyc;
        break;
      end
    end
  endtask

  // Follows one write from its ack to the following IDLE cycle.
  task automatic observe(input string name, input logic rs, input logic [7:0] d, input int t_ack);
    int t_rise = -1;
    int t_fall = -1;
    int t_idle = -1;
    bit stable = 1'b1;
    bit ack_long = 1'b0;
    if (bus.o_lcd_rs !== rs || bus.o_lcd_dados !== d) stable = 1'b0;
    for (int i = 0; i < model_total(rs, d) + 20; i++) begin
      @(negedge clk);
      if (i == 0 && (bus.o_ack0 !== 1'b0 || bus.o_ack1 !== 1'b0)) ack_long = 1'b1;
      if (t_rise < 0 && (bus.o_lcd_rs !== rs || bus.o_lcd_dados !== d || bus.o_lcd_rw !== 1'b0))
        stable = 1'b0;
      if (t_rise < 0 && bus.o_lcd_en === 1'b1) t_rise = cyc;
      else if (t_rise >= 0 && t_fall < 0 && bus.o_lcd_en === 1'b0) t_fall = cyc;
      if (bus.o_busy === 1'b0) begin
        t_idle = cyc;
        break;
      end
    end
    checks++;
    if (ack_long) begin errors++; $display("FAIL %s ack_width: ack still high one cycle after grant", name); end
    checks++;
    if (!stable) begin errors++; $display("FAIL %s bus_setup: RS/DADOS/RW not %0b/%02h/0 up to EN rise", name, rs, d); end
    checks++;
    if (t_rise < 0 || t_rise - t_ack != int'(SETUP)) begin
      errors++; $display("FAIL %s setup_time: got %0d expected %0d", name, t_rise - t_ack, SETUP);
    end
    checks++;
    if (t_fall < 0 || t_fall - t_rise != int'(EN)) begin
      errors++; $display("FAIL %s en_width: got %0d expected %0d", name, t_fall - t_rise, EN);
    end
    checks++;
    if (t_idle < 0 || t_idle - t_ack != model_total(rs, d)) begin
      errors++; $display("FAIL %s busy_low: got %0d expected %0d", name, t_idle - t_ack, model_total(rs, d));
    end
    checks++;
    if (bus.o_lcd_dados !== d || bus.o_lcd_rs !== rs) begin
      errors++; $display("FAIL %s hold_in_idle: got %0b/%02h expected %0b/%02h", name, bus.o_lcd_rs, bus.o_lcd_dados, rs, d);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_lcd_en, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_dados, bus.o_ack0, bus.o_ack1, bus.o_busy} !== 14'b000_00000000_001) begin
      errors++; $display("FAIL reset_values: got %b expected 00000000000001",
        {bus.o_lcd_en, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_dados, bus.o_ack0, bus.o_ack1, bus.o_busy});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL wait_init_busy: got %b expected 1", bus.o_busy); end
  endtask

  task automatic test_init_gate();
    int acks = 0, ens = 0, which, t, t_raise;
    bus.i_rs0 = 1'b1; bus.i_data0 = 8'h41; bus.i_req0 = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (bus.o_ack0 === 1'b1) acks++;
      if (bus.o_lcd_en !== 1'b0) ens++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL no_init_ack: got %0d acks expected 0", acks); end
    checks++;
    if (ens != 0) begin errors++; $display("FAIL no_init_en: got %0d EN cycles expected 0", ens); end
    bus.i_init_done = 1'b1;
    t_raise = cyc;
    wait_ack(10, which, t);
    bus.i_req0 = 1'b0;
    checks++;
    if (which != model_winner(1'b1, 1'b0)) begin errors++; $display("FAIL init_ack_port: got %0d expected 0", which); end
    checks++;
    if (t - t_raise != 2) begin errors++; $display("FAIL init_ack_latency: got %0d expected 2", t - t_raise); end
    last_win = 0;
    observe("write_41", 1'b1, 8'h41, t);
  endtask

  task automatic test_long_cmd();
    int which, t1, t2;
    logic [7:0] d2;
    bus.i_rs1 = 1'b0; bus.i_data1 = 8'h01; bus.i_req1 = 1'b1;
    wait_ack(10, which, t1);
    checks++;
    if (which != model_winner(1'b0, 1'b1)) begin errors++; $display("FAIL long_ack_port: got %0d expected 1", which); end
    last_win = 1;
    d2 = 8'($urandom);
    bus.i_rs1 = 1'b1; bus.i_data1 = d2;
    observe("clear_cmd", 1'b0, 8'h01, t1);
    wait_ack(5, which, t2);
    bus.i_req1 = 1'b0;
    checks++;
    if (which != 1 || t2 - t1 != 1 + model_total(1'b0, 8'h01)) begin
      errors++; $display("FAIL long_next_ack: got port %0d after %0d expected port 1 after %0d", which, t2 - t1, 1 + model_total(1'b0, 8'h01));
    end
    observe("held_req1", 1'b1, d2, t2);
  endtask

  task automatic test_back_to_back();
    int which, t, t_prev = 0, exp;
    logic [7:0] d [2];
    d[0] = 8'($urandom); d[1] = 8'($urandom);
    bus.i_rs0 = 1'b1; bus.i_rs1 = 1'b1; bus.i_data0 = d[0]; bus.i_data1 = d[1];
    bus.i_req0 = 1'b1; bus.i_req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = model_winner(1'b1, 1'b1);
      wait_ack(LONG + 100, which, t);
      checks++;
      if (which != exp || exp != (k % 2)) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, which, k % 2); end
      checks++;
      if (bus.o_lcd_dados !== d[exp]) begin errors++; $display("FAIL rr_data[%0d]: got %02h expected %02h", k, bus.o_lcd_dados, d[exp]); end
      if (k > 0) begin
        checks++;
        if (t - t_prev != 1 + int'(SETUP + EN + HOLD + EXEC)) begin
          errors++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", k, t - t_prev, 1 + SETUP + EN + HOLD + EXEC);
        end
      end
      last_win = exp;
      t_prev = t;
      if (k == 3) begin
        bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
        observe("rr_last", 1'b1, d[exp], t);
      end else begin
        d[exp] = 8'($urandom);
        if (exp == 0) bus.i_data0 = d[0]; else bus.i_data1 = d[1];
      end
    end
  endtask

  task automatic test_init_drop();
    int which, t0, t, t_r, en_cnt = 0, busy_low = 0, acks = 0;
    logic [7:0] d1, d2;
    d1 = 8'($urandom); d2 = 8'($urandom);
    bus.i_rs0 = 1'b1; bus.i_data0 = d1; bus.i_req0 = 1'b1;
    wait_ack(10, which, t0);
    checks++;
    if (which != model_winner(1'b1, 1'b0)) begin errors++; $display("FAIL drop_ack_port: got %0d expected 0", which); end
    last_win = 0;
    bus.i_data0 = d2;
    for (int i = 0; i < model_total(1'b1, d1) + 60; i++) begin
      @(negedge clk);
      if (bus.o_lcd_en === 1'b1) begin
        en_cnt++;
        if (en_cnt == 5) bus.i_init_done = 1'b0;
      end
      if (bus.o_busy !== 1'b1) busy_low++;
      if (bus.o_ack0 !== 1'b0 || bus.o_ack1 !== 1'b0) acks++;
    end
    checks++;
    if (en_cnt != int'(EN)) begin errors++; $display("FAIL drop_en_width: got %0d expected %0d", en_cnt, EN); end
    checks++;
    if (busy_low != 0) begin errors++; $display("FAIL drop_busy: busy low %0d cycles expected 0", busy_low); end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL drop_no_ack: got %0d acks expected 0", acks); end
    bus.i_init_done = 1'b1;
    t_r = cyc;
    wait_ack(10, which, t);
    bus.i_req0 = 1'b0;
    checks++;
    if (which != 0 || t - t_r != 2) begin
      errors++; $display("FAIL drop_resume: got port %0d after %0d expected port 0 after 2", which, t - t_r);
    end
    observe("drop_resume", 1'b1, d2, t);
  endtask

  task automatic test_reset_mid_pulse();
    int which, t, t_r, seen = 0;
    logic [7:0] d0;
    bus.i_rs0 = 1'b1; bus.i_data0 = 8'($urandom); bus.i_req0 = 1'b1;
    wait_ack(10, which, t);
    bus.i_req0 = 1'b0;
    last_win = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(negedge clk);
      if (bus.o_lcd_en === 1'b1) seen++;
    end
    checks++;
    if (seen != 3) begin errors++; $display("FAIL rst_en_rise: EN high %0d cycles expected 3", seen); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_lcd_en, bus.o_lcd_rs, bus.o_lcd_dados, bus.o_ack0, bus.o_ack1, bus.o_busy} !== 13'b00_00000000_001) begin
      errors++; $display("FAIL rst_async: got %b expected 0000000000001",
        {bus.o_lcd_en, bus.o_lcd_rs, bus.o_lcd_dados, bus.o_ack0, bus.o_ack1, bus.o_busy});
    end
    last_win = 1;
    d0 = 8'($urandom);
    bus.i_data0 = d0; bus.i_data1 = 8'($urandom); bus.i_rs1 = 1'b1;
    bus.i_req0 = 1'b1; bus.i_req1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    t_r = cyc;
    wait_ack(10, which, t);
    bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
    checks++;
    if (which != model_winner(1'b1, 1'b1) || t - t_r != 2) begin
      errors++; $display("FAIL rst_first_grant: got port %0d after %0d expected port 0 after 2", which, t - t_r);
    end
    last_win = 0;
    observe("rst_first", 1'b1, d0, t);
  endtask

  task automatic test_random();
    int which, t, t_set, exp, mode;
    logic       r0, r1;
    logic       rs [2];
    logic [7:0] d [2];
    for (int n = 0; n < 12; n++) begin
      mode = int'($urandom_range(0, 2));
      r0 = (mode != 1); r1 = (mode != 0);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          rs[p] = 1'b0; d[p] = 8'($urandom_range(1, 3));
        end else begin
          rs[p] = 1'($urandom_range(0, 1)); d[p] = 8'($urandom);
        end
      end
      bus.i_rs0 = rs[0]; bus.i_data0 = d[0]; bus.i_rs1 = rs[1]; bus.i_data1 = d[1];
      bus.i_req0 = r0; bus.i_req1 = r1;
      exp = model_winner(r0, r1);
      t_set = cyc;
      wait_ack(10, which, t);
      bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
      checks++;
      if (which != exp || t - t_set != 1) begin
        errors++; $display("FAIL rand_grant[%0d]: got port %0d after %0d expected port %0d after 1", n, which, t - t_set, exp);
      end
      last_win = exp;
      observe($sformatf("rand[%0d]", n), rs[exp], d[exp], t);
    end
  endtask

  initial begin
    bus.i_init_done = 1'b0;
    bus.i_req0 = 1'b0; bus.i_rs0 = 1'b0; bus.i_data0 = 8'h00;
    bus.i_req1 = 1'b0; bus.i_rs1 = 1'b0; bus.i_data1 = 8'h00;
    test_reset();
    test_init_gate();
    test_long_cmd();
    test_back_to_back();
    test_init_drop();
    test_reset_mid_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_write_scheduler.md
Name: lcd_write_scheduler

Overview:
Shares the character LCD bus between two requesters (game/text logic on port 0, status/menu logic on port 1) once power-on initialisation has finished. It arbitrates round-robin, latches one command or data byte per grant, generates the LCD_EN strobe with setup, hold and execution timing, then returns to arbitration. It sits between the LCD init controller (its idle output drives init_done) and the LCD pins; a top-level mux hands the pins to this block when init_done=1.

Parameters:
SETUP_CYC, 4, Clock cycles RS/RW/DADOS are stable before LCD_EN rises (≥40 ns at 50 MHz).
EN_CYC, 25, LCD_EN high width in cycles (500 ns).
HOLD_CYC, 4, Cycles bus is held after LCD_EN falls.
EXEC_CYC, 2000, Wait after a normal command/data write (40 µs).
LONG_EXEC_CYC, 82000, Wait after Clear Display / Return Home (1.64 ms).
CNT_W, 17, Delay counter width; must hold LONG_EXEC_CYC.

Ports:
Clock  in  1  System clock, 50 MHz.
Reset  in  1  Asynchronous, active-low reset.
init_done  in  1  High when the LCD init controller is idle; level, may drop at any time.
req0  in  1  Requester 0 write request; held until ack0.
rs0  in  1  Requester 0 RS (0 = command, 1 = data).
data0  in  8  Requester 0 byte.
ack0  out  1  One-cycle pulse: requester 0 byte latched.
req1  in  1  Requester 1 write request.
rs1  in  1  Requester 1 RS.
data1  in  8  Requester 1 byte.
ack1  out  1  One-cycle pulse: requester 1 byte latched.
LCD_EN  out  1  LCD enable strobe.
LCD_RS  out  1  LCD register select.
LCD_RW  out  1  LCD read/write; always 0 (write-only).
LCD_DADOS  out  8  LCD data bus.
busy  out  1  High in every state except IDLE.

Behaviour:
- Reset (async, Reset=0): state WAIT_INIT; LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DADOS=0, ack0=ack1=0, busy=1, counter=0, rr_last=1 (so requester 0 wins first).
- All outputs registered; LCD_RW tied low.
- States: WAIT_INIT -> IDLE -> SETUP -> PULSE -> HOLD -> EXEC -> IDLE.
- WAIT_INIT: stay until init_done=1, then go to IDLE. No ack is issued while in WAIT_INIT.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not equal to rr_last.
  - On grant: latch rs/data into LCD_RS/LCD_DADOS, pulse the matching ack for 1 cycle, update rr_last, clear the counter, go to SETUP.
  - Grant-to-ack latency is 1 cycle (ack is registered in the same edge that leaves IDLE).
- SETUP: count SETUP_CYC cycles, then LCD_EN<=1 and go to PULSE.
- PULSE: count EN_CYC cycles, then LCD_EN<=0 and go to HOLD.
- HOLD: count HOLD_CYC cycles, go to EXEC.
- EXEC:
  - Wait LONG_EXEC_CYC if the latched byte has RS=0 and is 0x01, 0x02 or 0x03; otherwise wait EXEC_CYC.
  - Then go to IDLE.
- Counter: compare is counter == N-1, then reset to 0; the counter never wraps.
- Total write time (normal byte) = 1 + SETUP_CYC + EN_CYC + HOLD_CYC + EXEC_CYC cycles from grant to the next IDLE.
- A req dropped before its ack is ignored. A req held after its ack is treated as a new request.
- init_done falling in IDLE: go to WAIT_INIT.
- init_done falling mid-transfer: finish the transfer through EXEC, then go to WAIT_INIT instead of IDLE.
- LCD_DADOS and LCD_RS hold their value until the next grant; they are not cleared in IDLE.
- Reset mid-PULSE: LCD_EN drops immediately (asynchronous).

Decomposition:
- Shared package lcd_pkg:
  - State encoding (3-bit).
  - Command constants: CMD_CLEAR=8'h01, CMD_HOME=8'h02.
  - Timing defaults.
- Sub-module lcd_rr_arbiter: 2-way combinational round-robin grant, with inputs req[1:0] and rr_last and output grant[1:0], one-hot or zero.

Test Plan:
- No init_done, req0=1 for 10 µs -> no ack0, LCD_EN stays 0. Raise init_done -> ack0 within 2 cycles.
- req0 data 8'h41 rs=1 -> LCD_RS=1, LCD_DADOS=8'h41 stable 4 cycles before LCD_EN; LCD_EN high exactly 25 cycles; busy low 2033 cycles after ack0.
- req0 and req1 held high together for 4 transfers -> ack order 0,1,0,1.
- req1 command 8'h01 rs=0 -> EXEC lasts 82000 cycles; next ack no earlier than 82034 cycles after ack1.
- init_done drops during PULSE -> EN pulse and EXEC complete, then state WAIT_INIT; pending req0 gets no ack until init_done returns.
- Reset asserted while LCD_EN=1 -> LCD_EN=0 the same cycle, outputs at reset values; after release and init_done, first grant goes to requester 0.
